// File: rtl/goertzel_coef_engine_if.sv
// Run-settings / coefficient-result bundle between the configuration registers,
// the coefficient engine and the Goertzel filter bank.
interface goertzel_coef_engine_if #(
  parameter int NF = 11,
  parameter int W  = 64
);
  logic                  start;
  logic [31:0]           num_samp_i;
  logic [31:0]           samp_freq_i;
  logic [NF-1:0][31:0]   freq_i;
  logic [NF-1:0]         chan_en_i;
  logic                  busy;
  logic                  valid;
  logic                  err_dbz;
  logic                  err_ovf;
  logic [NF-1:0][W-1:0]  k_arr_o;
  logic [W-1:0]          ang_coef_o;
  logic [W-1:0]          ns_coef_o;

  modport master (
    output start, num_samp_i, samp_freq_i, freq_i, chan_en_i,
    input  busy, valid, err_dbz, err_ovf, k_arr_o, ang_coef_o, ns_coef_o
  );

  modport slave (
    input  start, num_samp_i, samp_freq_i, freq_i, chan_en_i,
    output busy, valid, err_dbz, err_ovf, k_arr_o, ang_coef_o, ns_coef_o
  );
endinterface

// File: rtl/goertzel_coef_engine.sv
// Per-run Goertzel coefficient engine: df, k[i], 2pi/N and HCOEF/N computed
// one after another on a single shared restoring divider.
module goertzel_coef_engine #(
  parameter int NF = 11,
  parameter int IW = 20,
  parameter int FW = 44,
  parameter logic [IW+FW-1:0] PI2   = 64'h00006_487ED5110B4,
  parameter logic [IW+FW-1:0] HCOEF = 64'h00027_64D6A161E4F
) (
  input logic              clk,
  input logic              rstn,
  goertzel_coef_engine_if.slave bus
);
  localparam int W   = IW + FW;
  localparam int QW  = W + FW;
  localparam int OPW = $clog2(NF + 3);
  localparam int CW  = (NF > 1) ? $clog2(NF) : 1;
  localparam int QCW = $clog2(QW + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_WB, S_DONE} state_t;

  state_t         r_state;
  logic [OPW-1:0] r_op;
  logic [QCW-1:0] r_cnt;
  logic [W-1:0]   r_n, r_fs, r_df, r_b, r_rem;
  logic [W-1:0]   r_f [NF];
  logic [NF-1:0]  r_en;
  logic [QW-1:0]  r_dvd;

  logic           w_trunc, w_skip, w_ge, w_dbz, w_ovf;
  logic [CW-1:0]  w_ch;
  logic [W-1:0]   w_a, w_b, w_sub, w_res;
  logic [W:0]     w_sh;

  function automatic logic [W-1:0] to_fx(input logic [31:0] x);
    return {x[IW-1:0], {FW{1'b0}}};
  endfunction

  function automatic logic trunc(input logic [31:0] x);
    return (x >> IW) != 32'd0;
  endfunction

  // Integer bits lost in conversion count as overflow, but only for channels in use
  always_comb begin
    w_trunc = trunc(bus.num_samp_i) | trunc(bus.samp_freq_i);
    for (int i = 0; i < NF; i++)
      if (bus.chan_en_i[i] && trunc(bus.freq_i[i])) w_trunc = 1'b1;
  end

  assign w_ch = CW'(r_op - OPW'(1));

  always_comb begin
    w_a    = r_fs;
    w_b    = r_n;
    w_skip = 1'b0;
    if (r_op == OPW'(0)) begin
      w_a = r_fs;
    end else if (r_op <= OPW'(NF)) begin
      w_a    = r_f[w_ch];
      w_b    = r_df;
      w_skip = !r_en[w_ch];
    end else if (r_op == OPW'(NF + 1)) begin
      w_a = PI2;
    end else begin
      w_a = HCOEF;
    end
  end

  // Restoring step: the remainder stays below the divisor, so W bits hold it
  assign w_sh  = {r_rem, r_dvd[QW-1]};
  assign w_ge  = w_sh >= {1'b0, r_b};
  assign w_sub = w_sh[W-1:0] - r_b;

  assign w_dbz = (r_b == '0);
  assign w_ovf = !w_dbz && (|r_dvd[QW-1:W]);
  assign w_res = (w_dbz || w_ovf) ? '1 : r_dvd[W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_cnt          <= '0;
      r_n            <= '0;
      r_fs           <= '0;
      r_df           <= '0;
      r_b            <= '0;
      r_rem          <= '0;
      r_dvd          <= '0;
      r_en           <= '0;
      for (int i = 0; i < NF; i++) r_f[i] <= '0;
      bus.busy       <= 1'b0;
      bus.valid      <= 1'b0;
      bus.err_dbz    <= 1'b0;
      bus.err_ovf    <= 1'b0;
      bus.k_arr_o    <= '0;
      bus.ang_coef_o <= '0;
      bus.ns_coef_o  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_n            <= to_fx(bus.num_samp_i);
            r_fs           <= to_fx(bus.samp_freq_i);
            for (int i = 0; i < NF; i++) r_f[i] <= to_fx(bus.freq_i[i]);
            r_en           <= bus.chan_en_i;
            r_df           <= '0;
            r_op           <= '0;
            bus.busy       <= 1'b1;
            bus.valid      <= 1'b0;
            bus.err_dbz    <= 1'b0;
            bus.err_ovf    <= w_trunc;
            bus.k_arr_o    <= '0;
            bus.ang_coef_o <= '0;
            bus.ns_coef_o  <= '0;
            r_state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The final op (HCOEF/N) is never skipped, so a skip never ends the run
          if (w_skip) begin
            bus.k_arr_o[w_ch] <= '0;
            r_op              <= r_op + OPW'(1);
          end else begin
            r_b     <= w_b;
            r_rem   <= '0;
            r_dvd   <= {w_a, {FW{1'b0}}};
            r_cnt   <= '0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_rem <= w_ge ? w_sub : w_sh[W-1:0];
          r_dvd <= {r_dvd[QW-2:0], w_ge};
          r_cnt <= r_cnt + QCW'(1);
          if (r_cnt == QCW'(QW - 1)) r_state <= S_WB;
        end
        S_WB: begin
          if (w_dbz) bus.err_dbz <= 1'b1;
          if (w_ovf) bus.err_ovf <= 1'b1;
          if (r_op == OPW'(0))             r_df              <= w_res;
          else if (r_op <= OPW'(NF))       bus.k_arr_o[w_ch] <= w_res;
          else if (r_op == OPW'(NF + 1))   bus.ang_coef_o    <= w_res;
          else                             bus.ns_coef_o     <= w_res;
          if (r_op == OPW'(NF + 2)) begin
            bus.busy  <= 1'b0;
            bus.valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_op    <= r_op + OPW'(1);
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_goertzel_coef_engine.sv
// Directed bench for goertzel_coef_engine (NF=4, 16.16 format) with a result scoreboard.
module tb_goertzel_coef_engine;
  localparam logic [31:0] PI2_T   = 32'h0006487E;
  localparam logic [31:0] HCOEF_T = 32'h002764D6;

  typedef struct {
    logic [3:0][31:0] k;
    logic [31:0]      df;
    logic [31:0]      ang;
    logic [31:0]      ns;
    logic             dbz;
    logic             ovf;
    int               lat;
  } exp_t;

  logic clk, rstn;
  int   checks, errors;
  exp_t sb [$];

  goertzel_coef_engine_if #(.NF(4), .W(32)) bus ();

  goertzel_coef_engine #(
    .NF(4), .IW(16), .FW(16), .PI2(PI2_T), .HCOEF(HCOEF_T)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference quotient floor(a*2^16/b) in 16.16, saturating; returns {dbz, ovf, value}
  function automatic logic [33:0] mdiv(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] q;
    if (b == 32'h0) return {2'b10, 32'hFFFF_FFFF};
    q = {16'h0, a, 16'h0} / {32'h0, b};
    if (q[63:32] != 32'h0) return {2'b01, 32'hFFFF_FFFF};
    return {2'b00, q[31:0]};
  endfunction

  function automatic exp_t model(input logic [31:0] n, input logic [31:0] fs,
                                 input logic [3:0][31:0] f, input logic [3:0] en);
    exp_t        e;
    logic [33:0] r;
    logic [31:0] nfx;
    int          ecnt;
    e.ovf = (n[31:16] != 16'h0) || (fs[31:16] != 16'h0);
    e.dbz = 1'b0;
    nfx   = {n[15:0], 16'h0};
    r = mdiv({fs[15:0], 16'h0}, nfx);
    e.df = r[31:0]; e.dbz |= r[33]; e.ovf |= r[32];
    e.k = '0;
    ecnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        ecnt++;
        if (f[i][31:16] != 16'h0) e.ovf = 1'b1;
        r = mdiv({f[i][15:0], 16'h0}, e.df);
        e.k[i] = r[31:0]; e.dbz |= r[33]; e.ovf |= r[32];
      end
    end
    r = mdiv(PI2_T, nfx);
    e.ang = r[31:0]; e.dbz |= r[33]; e.ovf |= r[32];
    r = mdiv(HCOEF_T, nfx);
    e.ns = r[31:0]; e.dbz |= r[33]; e.ovf |= r[32];
    e.lat = (3 + ecnt) * 50 + (4 - ecnt);
    return e;
  endfunction

  task automatic run(input string nm, input logic [31:0] n, input logic [31:0] fs,
                     input logic [3:0][31:0] f, input logic [3:0] en, input exp_t e,
                     input bit poke);
    exp_t got;
    int   cyc;
    @(negedge clk);
    bus.num_samp_i  = n;
    bus.samp_freq_i = fs;
    bus.freq_i      = f;
    bus.chan_en_i   = en;
    bus.start       = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "_acc_busy"},  64'(bus.busy), 64'd1);
    chk({nm, "_acc_valid"}, 64'(bus.valid), 64'd0);
    chk({nm, "_acc_dbz"},   64'(bus.err_dbz), 64'd0);
    if (!e.ovf) chk({nm, "_acc_ovf"}, 64'(bus.err_ovf), 64'd0);
    chk({nm, "_acc_clr"}, 64'((|bus.k_arr_o) | (|bus.ang_coef_o) | (|bus.ns_coef_o)), 64'd0);
    cyc = 0;
    while (!bus.valid && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 100) begin
        bus.start       = 1'b1;
        bus.num_samp_i  = 32'd7;
        bus.freq_i      = '0;
        bus.chan_en_i   = 4'h1;
      end
      if (poke && cyc == 101) bus.start = 1'b0;
    end
    got = sb.pop_front();
    chk({nm, "_latency"}, 64'(cyc), 64'(got.lat));
    chk({nm, "_busy_done"}, 64'(bus.busy), 64'd0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_k%0d", nm, i), 64'(bus.k_arr_o[i]), 64'(got.k[i]));
    chk({nm, "_df"},  64'(dut.r_df), 64'(got.df));
    chk({nm, "_ang"}, 64'(bus.ang_coef_o), 64'(got.ang));
    chk({nm, "_ns"},  64'(bus.ns_coef_o), 64'(got.ns));
    chk({nm, "_dbz"}, 64'(bus.err_dbz), 64'(got.dbz));
    chk({nm, "_ovf"}, 64'(bus.err_ovf), 64'(got.ovf));
  endtask

  initial begin
    logic [3:0][31:0] f;
    exp_t             nom, msk, e;
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.num_samp_i = '0;
    bus.samp_freq_i = '0;
    bus.freq_i = '0;
    bus.chan_en_i = '0;

    nom.k = {32'h00100000, 32'h0, 32'h00400000, 32'h00200000};
    nom.df = 32'h001F4000; nom.ang = 32'h00000648; nom.ns = 32'h00002764;
    nom.dbz = 1'b0; nom.ovf = 1'b0; nom.lat = 350;
    msk = nom;
    msk.k = {32'h0, 32'h0, 32'h0, 32'h00200000};
    msk.lat = 252;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_err",   64'({bus.err_dbz, bus.err_ovf}), 64'd0);
    chk("rst_res",   64'((|bus.k_arr_o) | (|bus.ang_coef_o) | (|bus.ns_coef_o)), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    f = {32'd500, 32'd0, 32'd2000, 32'd1000};
    run("nom", 32'd256, 32'd8000, f, 4'hF, nom, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("nom_hold_valid", 64'(bus.valid), 64'd1);

    run("mask", 32'd256, 32'd8000, f, 4'h5, msk, 1'b0);

    e = model(32'd0, 32'd8000, '0, 4'hF);
    run("dbz", 32'd0, 32'd8000, '0, 4'hF, e, 1'b0);

    f = {32'd0, 32'd0, 32'd0, 32'd65535};
    e = model(32'd65535, 32'd2, f, 4'hF);
    run("ovf", 32'd65535, 32'd2, f, 4'hF, e, 1'b0);

    e = model(32'h00010000, 32'd8000, '0, 4'hF);
    run("trunc", 32'h00010000, 32'd8000, '0, 4'hF, e, 1'b0);

    // Restart from an errored DONE, with a stray start and input changes mid-run
    f = {32'd500, 32'd0, 32'd2000, 32'd1000};
    run("restart", 32'd256, 32'd8000, f, 4'hF, nom, 1'b1);

    @(negedge clk);
    bus.num_samp_i = 32'd256; bus.samp_freq_i = 32'd8000;
    bus.freq_i = f; bus.chan_en_i = 4'hF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_busy",  64'(bus.busy), 64'd0);
    chk("abort_valid", 64'(bus.valid), 64'd0);
    chk("abort_err",   64'({bus.err_dbz, bus.err_ovf}), 64'd0);
    chk("abort_res",   64'((|bus.k_arr_o) | (|bus.ang_coef_o) | (|bus.ns_coef_o)), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    run("post_rst", 32'd256, 32'd8000, f, 4'hF, nom, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
